// File: rtl/axi_dma_tap_pkg.sv
// Shared types and constants for the AXI DMA transfer tap.
// Capture-state encoding, channel codes, response codes and default LENGTH offsets.
package axi_dma_tap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HAVE_AW = 2'd1,
        ST_HAVE_W  = 2'd2,
        ST_WAIT_B  = 2'd3
    } cap_state_t;

    localparam logic CH_MM2S = 1'b0;
    localparam logic CH_S2MM = 1'b1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int unsigned DEF_MM2S_LEN_ADDR = 32'h28;
    localparam int unsigned DEF_S2MM_LEN_ADDR = 32'h58;

endpackage

// File: rtl/axi_dma_tap_fifo.sv
// Synchronous FIFO for pending transfer-start events.
// A push while full is accepted only when a pop happens on the same edge.
module axi_dma_tap_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_dma_transfer_tap.sv
// Passive AXI-Lite tap that queues writes to the DMA MM2S/S2MM LENGTH registers as events.
// Define AXI_DMA_TAP_BRESP_CHECK_EN to gate events on an OKAY write response.
import axi_dma_tap_pkg::*;

module axi_dma_transfer_tap #(
    parameter int          ADDR_W        = 10,
    parameter int          DATA_W        = 32,
    parameter int          LEN_W         = 26,
    parameter int unsigned MM2S_LEN_ADDR = DEF_MM2S_LEN_ADDR,
    parameter int unsigned S2MM_LEN_ADDR = DEF_S2MM_LEN_ADDR,
    parameter int          FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] tap_awaddr,
    input  logic              tap_awvalid,
    input  logic              tap_awready,
    input  logic [DATA_W-1:0] tap_wdata,
    input  logic              tap_wvalid,
    input  logic              tap_wready,
    input  logic [1:0]        tap_bresp,
    input  logic              tap_bvalid,
    input  logic              tap_bready,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              evt_ch,
    output logic [LEN_W-1:0]  evt_length,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    input  logic              clr_overflow
);

`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
    localparam cap_state_t PAIR_NEXT = ST_WAIT_B;
`else
    localparam cap_state_t PAIR_NEXT = ST_IDLE;
`endif

    cap_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;

    logic              aw_hs;
    logic              w_hs;
    logic              pair_done;
    logic              eval_en;
    logic [ADDR_W-1:0] addr_eff;
    logic [LEN_W-1:0]  len_eff;
    logic              hit_mm2s;
    logic              hit_s2mm;
    logic              push_req;
    logic              push_ch;

    logic              fifo_empty;
    logic              fifo_full;
    logic [LEN_W:0]    fifo_head;
    logic              drop;

    assign aw_hs = tap_awvalid && tap_awready;
    assign w_hs  = tap_wvalid && tap_wready;

    // A channel handshaking this cycle supplies its live value; otherwise use the latch.
    always_comb begin
        addr_eff  = aw_hs ? tap_awaddr : addr_q;
        len_eff   = w_hs ? tap_wdata[LEN_W-1:0] : len_q;
        pair_done = 1'b0;
        case (state)
            ST_IDLE:    pair_done = aw_hs && w_hs;
            ST_HAVE_AW: pair_done = w_hs;
            ST_HAVE_W:  pair_done = aw_hs;
            default:    pair_done = 1'b0;
        endcase
    end

`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
    logic b_hs;
    assign b_hs    = tap_bvalid && tap_bready;
    assign eval_en = (state == ST_WAIT_B) && b_hs && (tap_bresp == RESP_OKAY);
`else
    logic unused_b;
    assign unused_b = ^{tap_bresp, tap_bvalid, tap_bready, pair_done};
    assign eval_en  = pair_done;
`endif

    logic unused_wdata;
    assign unused_wdata = ^tap_wdata;

    always_comb begin
        hit_mm2s = (addr_eff == ADDR_W'(MM2S_LEN_ADDR)) && (len_eff != '0);
        hit_s2mm = (addr_eff == ADDR_W'(S2MM_LEN_ADDR)) && (len_eff != '0);
        push_req = eval_en && (hit_mm2s || hit_s2mm);
        push_ch  = hit_s2mm ? CH_S2MM : CH_MM2S;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            if (aw_hs) addr_q <= tap_awaddr;
            if (w_hs)  len_q  <= tap_wdata[LEN_W-1:0];
            case (state)
                ST_IDLE: begin
                    if (aw_hs && w_hs) state <= PAIR_NEXT;
                    else if (aw_hs)    state <= ST_HAVE_AW;
                    else if (w_hs)     state <= ST_HAVE_W;
                end
                ST_HAVE_AW: if (w_hs)  state <= PAIR_NEXT;
                ST_HAVE_W:  if (aw_hs) state <= PAIR_NEXT;
`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
                ST_WAIT_B:  if (b_hs)  state <= ST_IDLE;
`else
                ST_WAIT_B:             state <= ST_IDLE;
`endif
                default:               state <= ST_IDLE;
            endcase
        end
    end

    axi_dma_tap_fifo #(
        .WIDTH (1 + LEN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data ({push_ch, len_eff}),
        .pop       (evt_ready),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_ch     = fifo_head[LEN_W];
    assign evt_length = fifo_head[LEN_W-1:0];

    // Full implies non-empty, so evt_ready alone means the head pops this edge.
    assign drop = push_req && fifo_full && !evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_dma_transfer_tap.sv
// Directed bench for axi_dma_transfer_tap; follows AXI_DMA_TAP_BRESP_CHECK_EN like the RTL.
module tb_axi_dma_transfer_tap;
    import axi_dma_tap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  tap_awaddr;
    logic        tap_awvalid, tap_awready;
    logic [31:0] tap_wdata;
    logic        tap_wvalid, tap_wready;
    logic [1:0]  tap_bresp;
    logic        tap_bvalid, tap_bready;
    logic        evt_valid, evt_ready, evt_ch;
    logic [25:0] evt_length;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_dma_transfer_tap dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tap_awaddr   (tap_awaddr),
        .tap_awvalid  (tap_awvalid),
        .tap_awready  (tap_awready),
        .tap_wdata    (tap_wdata),
        .tap_wvalid   (tap_wvalid),
        .tap_wready   (tap_wready),
        .tap_bresp    (tap_bresp),
        .tap_bvalid   (tap_bvalid),
        .tap_bready   (tap_bready),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .evt_length   (evt_length),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All phase tasks start and end on a falling edge; the handshake lands on the rising edge between.
    task automatic phase_aw_w(input logic [9:0] a, input logic [31:0] d, input logic pop);
        tap_awaddr = a; tap_awvalid = 1'b1; tap_awready = 1'b1;
        tap_wdata  = d; tap_wvalid  = 1'b1; tap_wready  = 1'b1;
        evt_ready  = pop;
        @(negedge clk);
        tap_awvalid = 1'b0; tap_awready = 1'b0; tap_wvalid = 1'b0; tap_wready = 1'b0;
        evt_ready   = 1'b0;
    endtask

    task automatic phase_aw(input logic [9:0] a);
        tap_awaddr = a; tap_awvalid = 1'b1; tap_awready = 1'b1;
        @(negedge clk);
        tap_awvalid = 1'b0; tap_awready = 1'b0;
    endtask

    task automatic phase_w(input logic [31:0] d);
        tap_wdata = d; tap_wvalid = 1'b1; tap_wready = 1'b1;
        @(negedge clk);
        tap_wvalid = 1'b0; tap_wready = 1'b0;
    endtask

    task automatic phase_b(input logic [1:0] r, input logic pop);
        tap_bresp = r; tap_bvalid = 1'b1; tap_bready = 1'b1; evt_ready = pop;
        @(negedge clk);
        tap_bvalid = 1'b0; tap_bready = 1'b0; evt_ready = 1'b0; tap_bresp = 2'b00;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [1:0] r,
                            input logic pop);
`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
        phase_aw_w(a, d, 1'b0);
        phase_b(r, pop);
`else
        if (r != 2'b00) $display("note: bresp 0x%0h not checked in this build", r);
        phase_aw_w(a, d, pop);
`endif
    endtask

    task automatic pop_check(input string tag, input logic ch, input logic [25:0] len);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_ch"}, 32'(evt_ch), 32'(ch));
        chk({tag, "_len"}, 32'(evt_length), 32'(len));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tap_awaddr = '0; tap_awvalid = 0; tap_awready = 0;
        tap_wdata = '0; tap_wvalid = 0; tap_wready = 0;
        tap_bresp = 2'b00; tap_bvalid = 0; tap_bready = 0;
        evt_ready = 0; clr_overflow = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_ch", 32'(evt_ch), 32'd0);
        chk("rst_len", 32'(evt_length), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // AW+W together to S2MM LENGTH
        phase_aw_w(10'h58, 32'h1000, 1'b0);
`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
        chk("t1_before_b", 32'(evt_valid), 32'd0);
        chk("t1_wait_b", 32'(dut.state), 32'(ST_WAIT_B));
        phase_b(RESP_OKAY, 1'b0);
`endif
        pop_check("t1", CH_S2MM, 26'h1000);
        chk("t1_empty", 32'(evt_valid), 32'd0);

        // W first, AW three cycles later, to MM2S LENGTH
        phase_w(32'h40);
        repeat (2) @(negedge clk);
        chk("t2_early", 32'(evt_valid), 32'd0);
        chk("t2_have_w", 32'(dut.state), 32'(ST_HAVE_W));
        phase_aw(10'h28);
`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
        phase_b(RESP_OKAY, 1'b0);
`endif
        pop_check("t2", CH_MM2S, 26'h40);

        // Zero length, foreign address, and length bits above LEN_W only
        do_write(10'h58, 32'h0, RESP_OKAY, 1'b0);
        do_write(10'h30, 32'h80, RESP_OKAY, 1'b0);
        do_write(10'h28, 32'h0400_0000, RESP_OKAY, 1'b0);
        chk("t3_no_evt", 32'(evt_valid), 32'd0);
        chk("t3_idle", 32'(dut.state), 32'(ST_IDLE));
        do_write(10'h28, 32'hFC00_0010, RESP_OKAY, 1'b0);
        pop_check("t3_upper", CH_MM2S, 26'h10);

`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
        do_write(10'h58, 32'h200, 2'b10, 1'b0);
        chk("t4_slverr", 32'(evt_valid), 32'd0);
        do_write(10'h58, 32'h200, RESP_OKAY, 1'b0);
        pop_check("t4_okay", CH_S2MM, 26'h200);
`endif

        // Six writes into a depth-4 FIFO with no consumer
        for (int i = 0; i < 6; i++) begin
            do_write((i % 2 == 1) ? 10'h28 : 10'h58, 32'h101 + 32'(i), RESP_OKAY, 1'b0);
        end
        chk("t5_ovf", 32'(overflow), 32'd1);
        chk("t5_drop", 32'(drop_cnt), 32'd2);
        do_write(10'h58, 32'h107, RESP_OKAY, 1'b1);
        chk("t5_full_pop_drop", 32'(drop_cnt), 32'd2);
        pop_check("t5_e0", CH_MM2S, 26'h102);
        pop_check("t5_e1", CH_S2MM, 26'h103);
        pop_check("t5_e2", CH_MM2S, 26'h104);
        pop_check("t5_e3", CH_S2MM, 26'h107);
        chk("t5_drained", 32'(evt_valid), 32'd0);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        chk("t5_clr_ovf", 32'(overflow), 32'd0);
        chk("t5_clr_drop", 32'(drop_cnt), 32'd0);

        // Reset while in HAVE_AW with two events queued
        do_write(10'h58, 32'h5, RESP_OKAY, 1'b0);
        do_write(10'h28, 32'h6, RESP_OKAY, 1'b0);
        chk("t6_queued", 32'(evt_valid), 32'd1);
        phase_aw(10'h58);
        chk("t6_have_aw", 32'(dut.state), 32'(ST_HAVE_AW));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(evt_valid), 32'd0);
        chk("t6_rst_ch", 32'(evt_ch), 32'd0);
        chk("t6_rst_len", 32'(evt_length), 32'd0);
        chk("t6_rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        phase_w(32'h77);
`ifdef AXI_DMA_TAP_BRESP_CHECK_EN
        phase_b(RESP_OKAY, 1'b0);
`endif
        @(negedge clk);
        chk("t6_w_alone", 32'(evt_valid), 32'd0);
        chk("t6_have_w", 32'(dut.state), 32'(ST_HAVE_W));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_dma_transfer_tap.md
# axi_dma_transfer_tap

Passive monitor on the AXI-Lite control bus of the AXI DMA that detects completed writes to the MM2S and S2MM LENGTH registers and queues them as transfer-start events. It generalises the original S2MM-only length tap: full AW/W/B handshake tracking with independent arrival order, both DMA channels, parametrised widths, and a FIFO of pending events with overflow accounting. It sits beside the DMA control interconnect and feeds the trace/analysis logic; it never drives the bus.

## Interface
- ADDR_W, 10, AXI-Lite address width
- DATA_W, 32, AXI-Lite data width
- LEN_W, 26, transfer-length field width (LEN_W <= DATA_W)
- MM2S_LEN_ADDR, 'h28, MM2S LENGTH register offset
- S2MM_LEN_ADDR, 'h58, S2MM LENGTH register offset
- FIFO_DEPTH, 4, pending-event depth (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tap_awaddr / tap_awvalid / tap_awready  in  ADDR_W/1/1  observed write-address channel
- tap_wdata / tap_wvalid / tap_wready  in  DATA_W/1/1  observed write-data channel
- tap_bresp / tap_bvalid / tap_bready  in  2/1/1  observed write-response channel
- evt_valid  out  1  event available at FIFO head
- evt_ready  in  1  consumer pops head when evt_valid & evt_ready
- evt_ch  out  1  0 = MM2S, 1 = S2MM
- evt_length  out  LEN_W  requested length in bytes
- overflow  out  1  sticky: an event was dropped
- drop_cnt  out  8  saturating count of dropped events
- clr_overflow  in  1  clears overflow and drop_cnt

## Operation
- Handshake = valid & ready on the same clk edge. The tap observes only; no combinational path from tap_* to outputs.
- Capture FSM states: IDLE, HAVE_AW, HAVE_W, WAIT_B.
  - IDLE: AW hs alone -> HAVE_AW (latch addr); W hs alone -> HAVE_W (latch data); both same cycle -> pair complete.
  - HAVE_AW: W hs -> pair complete. HAVE_W: AW hs -> pair complete.
  - Pair complete -> WAIT_B (with macro) or IDLE with event evaluation (without).
  - WAIT_B: B hs -> IDLE; evaluate event.
- Event evaluation: match if latched addr == MM2S_LEN_ADDR (ch 0) or S2MM_LEN_ADDR (ch 1) and wdata[LEN_W-1:0] != 0; then push {ch, length}. Non-matching or zero-length writes complete the FSM with no push.
- Upper wdata bits above LEN_W ignored.
- FIFO full on push with no simultaneous pop: event dropped, overflow <= 1, drop_cnt += 1 saturating at 255. Push while full with a same-cycle pop is accepted.
- clr_overflow has priority over a same-cycle drop (result: overflow 0, drop_cnt 0).

## Timing
- Reset: FSM IDLE, FIFO empty, evt_valid 0, evt_ch 0, evt_length 0, overflow 0, drop_cnt 0. Reset mid-transaction discards latched AW/W and any queued events.
- Event latency: evt_valid high on the cycle after the completing handshake (W/AW without macro, B with macro) when the FIFO was empty.
- evt_ch/evt_length stable while evt_valid & !evt_ready.
- One write tracked at a time (AXI-Lite DMA slave); a second AW or W hs in HAVE_AW/HAVE_W/WAIT_B for the already-captured channel overwrites the latch (protocol violation, no assertion).
- Back-to-back events sustain one push per cycle.

## Configuration
- AXI_DMA_TAP_BRESP_CHECK_EN defined: WAIT_B used; event pushed only if the B hs carries tap_bresp == OKAY (2'b00); SLVERR/DECERR writes produce no event.
- Undefined: WAIT_B unreachable; event pushed on the cycle after the AW/W pair completes; tap_bresp/tap_bvalid/tap_bready unused.

## Structure
- Package axi_dma_tap_pkg: capture-state enum, channel codes (CH_MM2S, CH_S2MM), RESP_OKAY, default register offsets.
- One sub-module: axi_dma_tap_fifo (synchronous FIFO, width 1+LEN_W, depth FIFO_DEPTH, full/empty, same-cycle push/pop when full).

## Test plan
- AW+W same cycle to 'h58, wdata 'h1000, B OKAY -> one event ch 1, length 'h1000, evt_valid 1 cycle after B (macro) or after W (no macro).
- W to 'h28 data 'h40, AW three cycles later -> one event ch 0, length 'h40.
- Write 'h58 with data 0, and write 'h30 data 'h80 -> no events, FSM back to IDLE.
- With macro: write 'h58 data 'h200, bresp SLVERR -> no event; next write OKAY -> event.
- evt_ready held 0, six matching writes with FIFO_DEPTH 4 -> 4 events retained in order, overflow 1, drop_cnt 2; clr_overflow -> both 0.
- rst_n asserted in HAVE_AW with 2 queued events -> outputs at reset values; following W alone produces no event.
